lut_cpu_port: RTL and testbench

Synthesizable host-side responder for the cell rewriting and forwarding table: it owns the table storage and services CPU read and write cycles over a four-phase select/acknowledge handshake. It also serves single-cycle lookups from the cell forwarding path, which always has priority. After reset it clears every entry with an internal sweep before it accepts any CPU access.

---
 rtl/utopia_lut_pkg.sv | 21 ++
 rtl/lut_cpu_port_if.sv | 30 +++
 rtl/lut_ram.sv | 27 ++
 rtl/lut_cpu_port.sv | 130 +++++++++++++
 tb/tb_lut_cpu_port.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/utopia_lut_pkg.sv
// Shared types and defaults for the cell rewriting/forwarding table.
package utopia_lut_pkg;

  localparam int unsigned ASIZE_DEFAULT  = 8;
  localparam int unsigned NUM_TX_DEFAULT = 4;
  localparam int unsigned VPI_W          = 12;

  // One table entry: forwarding mask above the rewritten VPI.
  typedef struct packed {
    logic [NUM_TX_DEFAULT-1:0] fwd;
    logic [VPI_W-1:0]          vpi;
  } CellCfgType;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACCESS,
    ACK
  } lut_state_e;

endpackage

// File: rtl/lut_cpu_port_if.sv
// CPU select/acknowledge bus plus the cell-path lookup port.
interface lut_cpu_port_if #(
  parameter int unsigned ASIZE  = utopia_lut_pkg::ASIZE_DEFAULT,
  parameter int unsigned NUM_TX = utopia_lut_pkg::NUM_TX_DEFAULT
);

  localparam int unsigned DWIDTH = NUM_TX + utopia_lut_pkg::VPI_W;

  logic              cpu_sel;
  logic              cpu_wr;
  logic [ASIZE-1:0]  cpu_addr;
  logic [DWIDTH-1:0] cpu_wdata;
  logic [DWIDTH-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              lk_req;
  logic [ASIZE-1:0]  lk_addr;
  logic              lk_valid;
  logic [DWIDTH-1:0] lk_data;

  modport master (
    output cpu_sel, cpu_wr, cpu_addr, cpu_wdata, lk_req, lk_addr,
    input  cpu_rdata, cpu_ack, lk_valid, lk_data
  );

  modport slave (
    input  cpu_sel, cpu_wr, cpu_addr, cpu_wdata, lk_req, lk_addr,
    output cpu_rdata, cpu_ack, lk_valid, lk_data
  );

endinterface

// File: rtl/lut_ram.sv
// Single-port synchronous RAM, write-first, registered read output, no reset.
module lut_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Write-first: a write also presents the new data on dout.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/lut_cpu_port.sv
// Host-side responder for the forwarding table: clear sweep, CPU handshake,
// and single-cycle lookups that always win the RAM port.
module lut_cpu_port #(
  parameter int unsigned ASIZE  = utopia_lut_pkg::ASIZE_DEFAULT,
  parameter int unsigned NUM_TX = utopia_lut_pkg::NUM_TX_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  lut_cpu_port_if.slave  bus,
  output logic           init_done
);

  import utopia_lut_pkg::*;

  localparam int unsigned DWIDTH = NUM_TX + VPI_W;
  localparam int unsigned ARANGE = 1 << ASIZE;
  localparam int unsigned CW     = ASIZE + 1;

  lut_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              lk_valid_q, lk_valid_d;
  logic              lk_live_q, lk_live_d;

  logic              ram_we;
  logic [ASIZE-1:0]  ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic [DWIDTH-1:0] ram_dout;

  logic              cnt_last;
  logic              cpu_issue;

  assign cnt_last  = (cnt_q == CW'(ARANGE - 1));
  assign cpu_issue = (state_q == IDLE) && bus.cpu_sel && !bus.lk_req;

  lut_ram #(
    .AW (ASIZE),
    .DW (DWIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_last) state_d = IDLE;
      IDLE:    if (cpu_issue) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     if (!bus.cpu_sel) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // RAM port arbitration and next values of the output registers.
  always_comb begin
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    cpu_ack_d   = cpu_ack_q;
    cpu_rdata_d = cpu_rdata_q;
    lk_valid_d  = bus.lk_req;
    lk_live_d   = bus.lk_req && (state_q != INIT);
    ram_we      = 1'b0;
    ram_addr    = bus.lk_req ? bus.lk_addr : bus.cpu_addr;
    ram_din     = bus.cpu_wdata;
    case (state_q)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q[ASIZE-1:0];
        ram_din  = '0;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_last) init_done_d = 1'b1;
      end
      IDLE: begin
        ram_we = cpu_issue && bus.cpu_wr;
      end
      ACCESS: begin
        // dout still holds the CPU operation; write-first makes it the write data.
        cpu_rdata_d = ram_dout;
        cpu_ack_d   = 1'b1;
      end
      ACK: begin
        if (!bus.cpu_sel) cpu_ack_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      lk_valid_q  <= 1'b0;
      lk_live_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      lk_valid_q  <= lk_valid_d;
      lk_live_q   <= lk_live_d;
    end
  end

  // Lookup data comes straight off the registered RAM output, zeroed when not a real read.
  assign bus.lk_data   = lk_live_q ? ram_dout : '0;
  assign bus.lk_valid  = lk_valid_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_lut_cpu_port.sv
// Directed bench for lut_cpu_port with expected-result queues for CPU and lookup responses.
module tb_lut_cpu_port;

  import utopia_lut_pkg::*;

  localparam int unsigned DW = NUM_TX_DEFAULT + VPI_W;
  localparam int unsigned AW = ASIZE_DEFAULT;

  logic clk;
  logic rst_n;
  logic init_done;

  lut_cpu_port_if bus ();

  lut_cpu_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;
  int t0      = 0;
  int t_rel   = 0;

  logic [DW-1:0] lk_q[$];
  logic [DW-1:0] cpu_q[$];
  CellCfgType    cfg;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Advance one clock; check the lookup response of the request driven into that edge.
  task automatic cyc();
    logic was;
    was = bus.lk_req;
    @(negedge clk);
    cyc_n++;
    if (was) begin
      chk("lk_valid", 16'(bus.lk_valid), 16'd1);
      if (lk_q.size() != 0) chk("lk_data", bus.lk_data, lk_q.pop_front());
      else chk("lk_queue_empty", 16'd1, 16'd0);
    end else begin
      chk("lk_valid_idle", 16'(bus.lk_valid), 16'd0);
    end
    bus.lk_req = 1'b0;
  endtask

  task automatic lk_issue(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.lk_req  = 1'b1;
    bus.lk_addr = addr;
    lk_q.push_back(exp);
  endtask

  task automatic cpu_start(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
    bus.cpu_sel   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    cpu_q.push_back(exp);
    t0 = cyc_n;
  endtask

  task automatic cpu_wait(input string tag, input int lat);
    int guard;
    guard = 0;
    while (bus.cpu_ack !== 1'b1 && guard < 400) begin
      cyc();
      guard++;
    end
    chk({tag, "_latency"}, 16'(cyc_n - t0), 16'(lat));
    chk({tag, "_rdata"}, bus.cpu_rdata, cpu_q.pop_front());
  endtask

  task automatic cpu_end(input string tag);
    bus.cpu_sel = 1'b0;
    cyc();
    chk({tag, "_ack_release"}, 16'(bus.cpu_ack), 16'd0);
  endtask

  task automatic wait_init(input string tag);
    while (init_done !== 1'b1 && (cyc_n - t_rel) < 300) cyc();
    chk(tag, 16'(cyc_n - t_rel), 16'd256);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.cpu_sel   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.lk_req    = 1'b0;
    bus.lk_addr   = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_init_done", 16'(init_done), 16'd0);
    chk("rst_cpu_ack", 16'(bus.cpu_ack), 16'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
    chk("rst_lk_valid", 16'(bus.lk_valid), 16'd0);
    chk("rst_lk_data", bus.lk_data, 16'h0000);

    // Read of 0x00 held across the sweep
    rst_n = 1'b1;
    t_rel = cyc_n;
    cpu_start(1'b0, 8'h00, 16'h0000, 16'h0000);
    wait_init("init_length");
    chk("ack_not_before_init", 16'(bus.cpu_ack), 16'd0);
    cpu_wait("rd00_after_init", 258);
    cpu_end("rd00");

    // Write 0x2A, lookup one cycle after the write edge, read back
    cfg = '{fwd: 4'b0101, vpi: 12'h02A};
    cpu_start(1'b1, 8'h2A, cfg, 16'h502A);
    cyc();
    lk_issue(8'h2A, 16'h502A);
    cyc();
    cpu_wait("wr2a", 2);
    cpu_end("wr2a");
    cpu_start(1'b0, 8'h2A, 16'h0000, 16'h502A);
    cpu_wait("rd2a", 2);
    cpu_end("rd2a");

    // Five back-to-back lookups delay a pending read by five cycles
    cpu_start(1'b0, 8'h2A, 16'h0000, 16'h502A);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) lk_issue(8'h2A, 16'h502A);
      else            lk_issue(8'h01, 16'h0000);
      cyc();
    end
    cpu_wait("rd2a_contended", 7);
    cpu_end("rd2a_contended");

    // Lookup in the ACCESS cycle of a CPU read
    cpu_start(1'b1, 8'h10, 16'h1010, 16'h1010);
    cpu_wait("wr10", 2);
    cpu_end("wr10");
    cpu_start(1'b1, 8'h11, 16'h2011, 16'h2011);
    cpu_wait("wr11", 2);
    cpu_end("wr11");
    cpu_start(1'b0, 8'h10, 16'h0000, 16'h1010);
    cyc();
    lk_issue(8'h11, 16'h2011);
    cyc();
    cpu_wait("rd10_overlap", 2);
    cpu_end("rd10_overlap");

    // cpu_sel held through three ack cycles
    cpu_start(1'b1, 8'h30, 16'h1234, 16'h1234);
    cpu_wait("wr30", 2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) lk_issue(8'h30, 16'h1234);
      cyc();
      chk("hold_ack", 16'(bus.cpu_ack), 16'd1);
      chk("hold_rdata", bus.cpu_rdata, 16'h1234);
    end
    cpu_end("wr30");

    // cpu_sel dropped before ack: access completes, ack pulses once
    cpu_start(1'b0, 8'h2A, 16'h0000, 16'h502A);
    cyc();
    bus.cpu_sel = 1'b0;
    cyc();
    chk("pulse_ack_high", 16'(bus.cpu_ack), 16'd1);
    chk("pulse_rdata", bus.cpu_rdata, cpu_q.pop_front());
    cyc();
    chk("pulse_ack_low", 16'(bus.cpu_ack), 16'd0);

    // Write 0xFF, reset mid-ack, sweep clears it
    cpu_start(1'b1, 8'hFF, 16'hF0FF, 16'hF0FF);
    cpu_wait("wrff", 2);
    lk_issue(8'hFF, 16'hF0FF);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("async_ack_clear", 16'(bus.cpu_ack), 16'd0);
    chk("async_rdata_clear", bus.cpu_rdata, 16'h0000);
    chk("async_init_clear", 16'(init_done), 16'd0);
    bus.cpu_sel = 1'b0;
    cyc();
    rst_n = 1'b1;
    t_rel = cyc_n;
    repeat (10) cyc();
    lk_issue(8'hFF, 16'h0000);
    cyc();
    wait_init("init_length_again");
    cpu_start(1'b0, 8'hFF, 16'h0000, 16'h0000);
    cpu_wait("rdff_cleared", 2);
    cpu_end("rdff_cleared");
    lk_issue(8'hFF, 16'h0000);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
